tt_store_packer: RTL and testbench
==================================

// Module: tt_store_packer
// PURPOSE
// Buffers store-data uops from the vector datapath and packs them into OUT_W-bit beats toward the LSU, credit-flow-controlled.
// Parametrised successor of the single-instruction store FSM: ring buffer plus descriptor queue so instruction N+1 cracks while N drains.
// Adds per-beat byte count, last flag and byte-exact mask-store length.
// Sits between vector ID/issue and the memory store-data channel.
// PARAMETERS
// VLEN          256  vector register width in bits
// OUT_W         512  beat width in bits; OUT_W = K*VLEN, K in {1,2,4}
// BUF_DEPTH     16   VLEN-bit buffer entries, power of 2, >= 8
// STORE_CREDITS 4    beats the LSU accepts without credit return
// MAX_INSTR     2    completed-but-unsent store instructions queued
// PORTS
// i_clk            in   1                  clock
// i_reset          in   1                  synchronous active-high reset
// i_uop_fire       in   1                  uop accepted this cycle
// i_uop_is_store   in   1                  uop is a store-data uop
// i_uop_first      in   1                  first uop of instruction
// i_uop_last       in   1                  last uop of instruction
// i_uop_is_vsm     in   1                  mask store
// i_uop_is_vsr     in   1                  whole-register store
// i_uop_data_size  in   2                  log2 element bytes
// i_uop_vl         in   $clog2(VLEN+1)     vl, sampled on first uop
// i_uop_nfield     in   3                  vsr register count - 1 (0,1,3,7)
// i_store_data     in   VLEN               uop store data
// i_store_credit   in   1                  one credit returned
// o_store_valid    out  1                  beat sent this cycle (no ready)
// o_store_data     out  OUT_W              beat data
// o_store_last     out  1                  final beat of instruction
// o_store_nbytes   out  $clog2(OUT_W/8+1)  valid bytes in beat, from LSB
// o_stall          out  1                  upstream must not fire store uops
// BEHAVIOUR
// - Reset: pointers, counters, descriptor queue cleared; credits=STORE_CREDITS; all outputs 0 (o_store_data qualified by valid).
// - Reset mid-operation discards buffered data and queued descriptors; no beat is sent in the reset cycle.
// - Write: every fired store uop writes entry wptr, wptr+=1 mod BUF_DEPTH. First uop latches byte total:
//   vsr: (nfield+1)*VLEN/8; else vl==0: 0; vsm: ceil(vl/8); else vl<<data_size.
// - Last uop (may equal first) pushes descriptor {base ptr, uop count, bytes, beats=ceil(bytes/(OUT_W/8))}.
// - o_stall = desc_count==MAX_INSTR || (free_entries<8 && no instruction mid-crack); registered-state only, no input paths.
// - Store uop fire while o_stall=1 is illegal (bench assertion).
// - Read: o_store_valid = head descriptor present && beats_left>0 && credits>0. Beat j concatenates entries
//   base+j*K .. base+j*K+K-1 (mod BUF_DEPTH), lowest entry at LSB.
// - o_store_nbytes = min(bytes_left, OUT_W/8); o_store_last=1 on final beat; valid for one cycle per beat.
// - Pop on last beat: rptr += uop count, freeing all entries incl. unread ones; next descriptor may send next cycle.
// - Zero-beat descriptor (vl==0) pops in one cycle with o_store_valid=0.
// - credits_next = credits + i_store_credit - o_store_valid; same-cycle return and send nets zero; overflow is illegal (assertion).
// - Push and pop in the same cycle both take effect; free_entries updated by both.
// - Wrap-around: entries and beat spans cross BUF_DEPTH-1 -> 0 seamlessly.
// TESTING
// 1. LMUL1 e32 vl=8, one uop 0xA..A -> one beat, nbytes=32, last=1, data[255:0]=0xA..A.
// 2. LMUL4 e64 vl=16 (128B) -> 2 beats of 64B, entries 0-1 then 2-3, last only on beat 2.
// 3. vsm vl=20 -> one beat nbytes=3; vsr nfield=7 -> 4 beats nbytes=64; vl==0 -> no beat, stall clears.
// 4. Credits: hold i_store_credit=0, LMUL8 e64 vl=32 -> 4 beats then valid=0; one credit -> exactly one more beat.
// 5. Back-to-back: LMUL8 store then LMUL4 store cracked while first drains; wptr wraps 15->0; data in order, no loss.
// 6. Assert i_reset during SEND beat 2 -> valid=0 next cycle, credits=4, o_stall=0, new store works.

Source files
------------

// File: rtl/tt_store_packer.sv
// Packs VLEN-bit store-data uops into OUT_W-bit credit-controlled beats; a beat may go out the cycle after its instruction's last uop.
// o_stall is registered state only; beats are held while credits are zero.
module tt_store_packer #(
  parameter int VLEN          = 256,
  parameter int OUT_W         = 512,
  parameter int BUF_DEPTH     = 16,
  parameter int STORE_CREDITS = 4,
  parameter int MAX_INSTR     = 2
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_uop_fire,
  input  logic                         i_uop_is_store,
  input  logic                         i_uop_first,
  input  logic                         i_uop_last,
  input  logic                         i_uop_is_vsm,
  input  logic                         i_uop_is_vsr,
  input  logic [1:0]                   i_uop_data_size,
  input  logic [$clog2(VLEN+1)-1:0]    i_uop_vl,
  input  logic [2:0]                   i_uop_nfield,
  input  logic [VLEN-1:0]              i_store_data,
  input  logic                         i_store_credit,
  output logic                         o_store_valid,
  output logic [OUT_W-1:0]             o_store_data,
  output logic                         o_store_last,
  output logic [$clog2(OUT_W/8+1)-1:0] o_store_nbytes,
  output logic                         o_stall
);

  localparam int K     = OUT_W / VLEN;
  localparam int VLENB = VLEN / 8;
  localparam int OUT_B = OUT_W / 8;
  localparam int PW    = $clog2(BUF_DEPTH);
  localparam int CW    = PW + 1;
  localparam int BW    = $clog2(VLEN * 8 + 1);
  localparam int NBW   = $clog2(OUT_B + 1);
  localparam int CRW   = $clog2(STORE_CREDITS + 1);
  localparam int QW    = (MAX_INSTR > 1) ? $clog2(MAX_INSTR) : 1;
  localparam int QCW   = $clog2(MAX_INSTR + 1);

  typedef struct packed {
    logic [PW-1:0] base;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bytes;
    logic [BW-1:0] beats;
  } desc_t;

  logic [VLEN-1:0] r_mem [BUF_DEPTH];
  desc_t           r_dq  [MAX_INSTR];
  logic [QW-1:0]   r_dq_wr, r_dq_rd;
  logic [QCW-1:0]  r_dq_cnt;
  logic [PW-1:0]   r_wptr;
  logic [CW-1:0]   r_used;
  logic            r_cracking;
  logic [PW-1:0]   r_cur_base;
  logic [CW-1:0]   r_cur_cnt;
  logic [BW-1:0]   r_cur_bytes;
  logic [BW-1:0]   r_beat_idx;
  logic [BW-1:0]   r_bytes_done;
  logic [CRW-1:0]  r_credits;

  logic            w_wr, w_push, w_pop, w_send, w_last_beat, w_head_vld;
  logic [BW-1:0]   w_first_bytes, w_bytes, w_beats, w_bytes_left;
  logic [CW-1:0]   w_cnt, w_free;
  logic [PW-1:0]   w_base;
  logic [NBW-1:0]  w_nb;
  logic [OUT_W-1:0] w_beat;
  desc_t           w_head;

  assign w_wr   = i_uop_fire && i_uop_is_store;
  assign w_push = w_wr && i_uop_last;

  always_comb begin
    w_first_bytes = '0;
    if (i_uop_is_vsr)
      w_first_bytes = BW'((32'(i_uop_nfield) + 1) * VLENB);
    else if (i_uop_vl == '0)
      w_first_bytes = '0;
    else if (i_uop_is_vsm)
      w_first_bytes = BW'((32'(i_uop_vl) + 7) >> 3);
    else
      w_first_bytes = BW'(32'(i_uop_vl) << i_uop_data_size);
  end

  assign w_bytes = i_uop_first ? w_first_bytes : r_cur_bytes;
  assign w_cnt   = i_uop_first ? CW'(1) : r_cur_cnt + CW'(1);
  assign w_base  = i_uop_first ? r_wptr : r_cur_base;
  assign w_beats = BW'((32'(w_bytes) + OUT_B - 1) / OUT_B);

  assign w_head       = r_dq[r_dq_rd];
  assign w_head_vld   = (r_dq_cnt != '0);
  assign w_last_beat  = ((r_beat_idx + BW'(1)) == w_head.beats);
  assign w_send       = !i_reset && w_head_vld && (r_beat_idx != w_head.beats) && (r_credits != '0);
  // A zero-beat descriptor retires without ever presenting a beat.
  assign w_pop        = w_head_vld && ((w_head.beats == '0) || (w_send && w_last_beat));
  assign w_bytes_left = w_head.bytes - r_bytes_done;
  assign w_nb         = (w_bytes_left > BW'(OUT_B)) ? NBW'(OUT_B) : w_bytes_left[NBW-1:0];

  always_comb begin
    w_beat = '0;
    for (int k = 0; k < K; k++)
      w_beat[k*VLEN +: VLEN] = r_mem[w_head.base + PW'(r_beat_idx * K) + PW'(k)];
  end

  assign w_free         = CW'(BUF_DEPTH) - r_used;
  assign o_stall        = (r_dq_cnt == QCW'(MAX_INSTR)) || ((w_free < CW'(8)) && !r_cracking);
  assign o_store_valid  = w_send;
  assign o_store_data   = w_send ? w_beat : '0;
  assign o_store_last   = w_send && w_last_beat;
  assign o_store_nbytes = w_send ? w_nb : '0;

  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr)
      r_mem[r_wptr] <= i_store_data;
    if (!i_reset && w_push)
      r_dq[r_dq_wr] <= '{base: w_base, cnt: w_cnt, bytes: w_bytes, beats: w_beats};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_dq_wr      <= '0;
      r_dq_rd      <= '0;
      r_dq_cnt     <= '0;
      r_wptr       <= '0;
      r_used       <= '0;
      r_cracking   <= 1'b0;
      r_cur_base   <= '0;
      r_cur_cnt    <= '0;
      r_cur_bytes  <= '0;
      r_beat_idx   <= '0;
      r_bytes_done <= '0;
      r_credits    <= CRW'(STORE_CREDITS);
    end else begin
      if (w_wr) begin
        r_wptr      <= r_wptr + PW'(1);
        r_cracking  <= !i_uop_last;
        r_cur_base  <= w_base;
        r_cur_cnt   <= w_cnt;
        r_cur_bytes <= w_bytes;
      end
      if (w_push)
        r_dq_wr <= (r_dq_wr == QW'(MAX_INSTR - 1)) ? '0 : r_dq_wr + QW'(1);
      if (w_pop) begin
        r_dq_rd      <= (r_dq_rd == QW'(MAX_INSTR - 1)) ? '0 : r_dq_rd + QW'(1);
        r_beat_idx   <= '0;
        r_bytes_done <= '0;
      end else if (w_send) begin
        r_beat_idx   <= r_beat_idx + BW'(1);
        r_bytes_done <= r_bytes_done + BW'(OUT_B);
      end
      r_dq_cnt  <= r_dq_cnt + QCW'(w_push) - QCW'(w_pop);
      // Popping frees every entry of the instruction, including ones no beat covered.
      r_used    <= r_used + CW'(w_wr) - (w_pop ? w_head.cnt : CW'(0));
      r_credits <= r_credits + CRW'(i_store_credit) - CRW'(w_send);
    end
  end

endmodule

// File: tb/tb_tt_store_packer.sv
// Random and directed store instructions against a byte-stream reference model with a beat scoreboard.
module tb_tt_store_packer;
  localparam int VLEN = 256, OUT_W = 512, BUF_DEPTH = 16, CRED = 4, MAXI = 2;
  localparam int VLENB = VLEN / 8, OUT_B = OUT_W / 8;
  localparam int VLW = $clog2(VLEN + 1), NBW = $clog2(OUT_B + 1);

  logic i_clk = 1'b0;
  logic i_reset, i_uop_fire, i_uop_is_store, i_uop_first, i_uop_last, i_uop_is_vsm, i_uop_is_vsr;
  logic [1:0] i_uop_data_size;
  logic [VLW-1:0] i_uop_vl;
  logic [2:0] i_uop_nfield;
  logic [VLEN-1:0] i_store_data;
  logic i_store_credit;
  logic o_store_valid, o_store_last, o_stall;
  logic [OUT_W-1:0] o_store_data;
  logic [NBW-1:0] o_store_nbytes;

  tt_store_packer #(.VLEN(VLEN), .OUT_W(OUT_W), .BUF_DEPTH(BUF_DEPTH),
                    .STORE_CREDITS(CRED), .MAX_INSTR(MAXI)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_uop_fire(i_uop_fire), .i_uop_is_store(i_uop_is_store),
    .i_uop_first(i_uop_first), .i_uop_last(i_uop_last), .i_uop_is_vsm(i_uop_is_vsm),
    .i_uop_is_vsr(i_uop_is_vsr), .i_uop_data_size(i_uop_data_size), .i_uop_vl(i_uop_vl),
    .i_uop_nfield(i_uop_nfield), .i_store_data(i_store_data), .i_store_credit(i_store_credit),
    .o_store_valid(o_store_valid), .o_store_data(o_store_data), .o_store_last(o_store_last),
    .o_store_nbytes(o_store_nbytes), .o_stall(o_stall));

  always #5 i_clk = ~i_clk;

  typedef struct { logic [OUT_W-1:0] d; int nb; bit last; } beat_t;
  beat_t exp_q[$];
  int checks = 0, errors = 0, n_beats = 0, outstanding = 0, force_cred = 0;
  bit credit_en = 1'b1;

  task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] mk_mask(input int nb);
    logic [OUT_W-1:0] m;
    m = '0;
    for (int b = 0; b < OUT_B; b++)
      if (b < nb) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  // Monitor: scoreboard pops, credit accounting and LSU credit returns.
  initial begin
    beat_t e;
    bit ret;
    i_store_credit = 1'b0;
    forever begin
      @(negedge i_clk);
      if (i_reset) begin
        chk("valid_in_reset", OUT_W'(o_store_valid), OUT_W'(0));
        outstanding = 0;
        i_store_credit = 1'b0;
      end else begin
        if (o_store_valid) begin
          n_beats++;
          chk("credit_available", OUT_W'(outstanding < CRED), OUT_W'(1));
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat: got data %0h with nothing expected", o_store_data);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", o_store_data & mk_mask(e.nb), e.d);
            chk("beat_nbytes", OUT_W'(o_store_nbytes), OUT_W'(e.nb));
            chk("beat_last", OUT_W'(o_store_last), OUT_W'(e.last));
          end
        end
        ret = (outstanding > 0) && ((credit_en && $urandom_range(0, 3) != 0) || force_cred > 0);
        if (ret && force_cred > 0) force_cred--;
        i_store_credit = ret;
        outstanding = outstanding + int'(o_store_valid) - int'(ret);
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      i_uop_fire = $urandom_range(0, 1);
      i_uop_is_store = 1'b0;
      i_store_data = {8{$urandom()}};
      @(negedge i_clk);
    end
    i_uop_fire = 1'b0;
  endtask

  task automatic wait_nostall();
    int g = 0;
    while (o_stall && g < 2000) begin @(negedge i_clk); g++; end
    if (o_stall) begin
      checks++; errors++;
      $display("FAIL stall_timeout: o_stall still 1 after %0d cycles", g);
    end
  endtask

  task automatic send_instr(input bit vsm, input bit vsr, input int ds, input int vl,
                            input int nf, input int lmul, input bit pat);
    byte unsigned q[$];
    int nu, bytes;
    logic [VLEN-1:0] d;
    beat_t bt;
    nu = vsr ? nf + 1 : (vsm ? 1 : lmul);
    if (vsr) bytes = (nf + 1) * VLENB;
    else if (vl == 0) bytes = 0;
    else if (vsm) bytes = (vl + 7) / 8;
    else bytes = vl * (1 << ds);
    for (int u = 0; u < nu; u++) begin
      i_uop_fire = 1'b0; i_uop_is_store = 1'b0;
      wait_nostall();
      if (pat) d = {8{32'hAAAA_AAAA}};
      else for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom();
      for (int b = 0; b < VLENB; b++) q.push_back(d[b*8 +: 8]);
      i_uop_fire = 1'b1; i_uop_is_store = 1'b1;
      i_uop_first = (u == 0); i_uop_last = (u == nu - 1);
      i_uop_is_vsm = vsm; i_uop_is_vsr = vsr;
      i_uop_data_size = 2'(ds); i_uop_vl = VLW'(vl); i_uop_nfield = 3'(nf);
      i_store_data = d;
      chk("no_fire_while_stall", OUT_W'(o_stall), OUT_W'(0));
      if (u == nu - 1) begin
        for (int j = 0; j * OUT_B < bytes; j++) begin
          bt.nb = bytes - j * OUT_B;
          if (bt.nb > OUT_B) bt.nb = OUT_B;
          bt.d = '0;
          for (int k = 0; k < bt.nb; k++) bt.d[k*8 +: 8] = q[j*OUT_B + k];
          bt.last = ((j + 1) * OUT_B >= bytes);
          exp_q.push_back(bt);
        end
      end
      @(negedge i_clk);
    end
    i_uop_fire = 1'b0; i_uop_is_store = 1'b0; i_uop_first = 1'b0; i_uop_last = 1'b0;
  endtask

  task automatic rand_instr();
    int kind, lmul, ds, vlmax, vl;
    int nfs[4] = '{0, 1, 3, 7};
    kind = $urandom_range(0, 2);
    if (kind == 0) send_instr(1'b0, 1'b1, 0, $urandom_range(0, VLEN), nfs[$urandom_range(0, 3)], 1, 1'b0);
    else if (kind == 1) send_instr(1'b1, 1'b0, 0, $urandom_range(0, VLEN), 0, 1, 1'b0);
    else begin
      lmul = 1 << $urandom_range(0, 3);
      ds = $urandom_range(0, 3);
      vlmax = (lmul * VLENB) >> ds;
      vl = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, vlmax);
      send_instr(1'b0, 1'b0, ds, vl, 0, lmul, 1'b0);
    end
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    while ((exp_q.size() != 0 || outstanding != 0) && g < 3000) begin @(negedge i_clk); g++; end
    repeat (3) @(negedge i_clk);
    chk({nm, "_drained"}, OUT_W'(exp_q.size()), OUT_W'(0));
    chk({nm, "_stall_clear"}, OUT_W'(o_stall), OUT_W'(0));
  endtask

  initial begin
    int b0;
    int g;
    i_reset = 1'b1; i_uop_fire = 1'b0; i_uop_is_store = 1'b0; i_uop_first = 1'b0; i_uop_last = 1'b0;
    i_uop_is_vsm = 1'b0; i_uop_is_vsr = 1'b0; i_uop_data_size = '0; i_uop_vl = '0;
    i_uop_nfield = '0; i_store_data = '0;
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("reset_valid", OUT_W'(o_store_valid), OUT_W'(0));
    chk("reset_stall", OUT_W'(o_stall), OUT_W'(0));
    chk("reset_nbytes", OUT_W'(o_store_nbytes), OUT_W'(0));
    chk("reset_last", OUT_W'(o_store_last), OUT_W'(0));

    b0 = n_beats; send_instr(1'b0, 1'b0, 2, 8, 0, 1, 1'b1); wait_drain("lmul1");
    chk("lmul1_beats", OUT_W'(n_beats - b0), OUT_W'(1));
    b0 = n_beats; send_instr(1'b0, 1'b0, 3, 16, 0, 4, 1'b0); wait_drain("lmul4");
    chk("lmul4_beats", OUT_W'(n_beats - b0), OUT_W'(2));
    b0 = n_beats;
    send_instr(1'b1, 1'b0, 0, 20, 0, 1, 1'b0);
    send_instr(1'b0, 1'b1, 0, 0, 7, 1, 1'b0);
    send_instr(1'b0, 1'b0, 0, 0, 0, 1, 1'b0);
    wait_drain("vsm_vsr_vl0");
    chk("vsm_vsr_vl0_beats", OUT_W'(n_beats - b0), OUT_W'(5));

    // Credits held: four beats, then exactly one more per returned credit.
    credit_en = 1'b0; b0 = n_beats;
    send_instr(1'b0, 1'b0, 3, 32, 0, 8, 1'b0);
    send_instr(1'b0, 1'b0, 3, 16, 0, 4, 1'b0);
    repeat (30) @(negedge i_clk);
    chk("credit_block_beats", OUT_W'(n_beats - b0), OUT_W'(4));
    chk("credit_block_valid", OUT_W'(o_store_valid), OUT_W'(0));
    force_cred = 1;
    repeat (30) @(negedge i_clk);
    chk("one_credit_beats", OUT_W'(n_beats - b0), OUT_W'(5));
    credit_en = 1'b1; wait_drain("credit");

    send_instr(1'b0, 1'b0, 3, 32, 0, 8, 1'b0);
    send_instr(1'b0, 1'b0, 2, 32, 0, 4, 1'b0);
    for (int i = 0; i < 60; i++) begin rand_instr(); idle($urandom_range(0, 3)); end
    wait_drain("random");

    // Reset while the second beat of an LMUL8 store is on the bus.
    credit_en = 1'b0; b0 = n_beats;
    send_instr(1'b0, 1'b0, 3, 32, 0, 8, 1'b0);
    g = 0;
    while (n_beats != b0 + 1 && g < 100) begin @(posedge i_clk); g++; end
    chk("reset_test_first_beat", OUT_W'(n_beats - b0), OUT_W'(1));
    #1 i_reset = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_q.delete();
    force_cred = 0;
    @(negedge i_clk);
    chk("post_reset_valid", OUT_W'(o_store_valid), OUT_W'(0));
    chk("post_reset_stall", OUT_W'(o_stall), OUT_W'(0));
    chk("post_reset_beats", OUT_W'(n_beats - b0), OUT_W'(1));
    b0 = n_beats;
    send_instr(1'b0, 1'b0, 3, 32, 0, 8, 1'b0);
    repeat (20) @(negedge i_clk);
    chk("post_reset_credit_beats", OUT_W'(n_beats - b0), OUT_W'(4));
    credit_en = 1'b1;
    send_instr(1'b0, 1'b0, 2, 8, 0, 1, 1'b1);
    wait_drain("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
